gelato_fetch_scheduler: RTL

Warp fetch scheduler sitting directly downstream of the split table's PC-table port. Each cycle it picks one fetch-eligible warp round-robin, from the per-warp PCs the split table publishes, and issues a fetch request to the instruction cache. The issued warp is then held off until decode returns an activate for it, so each warp has at most one instruction in the front end.

---
 rtl/gelato_types_pkg.sv | 32 +++
 rtl/gelato_rr_arbiter.sv | 36 +++
 rtl/gelato_fetch_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gelato_types_pkg.sv
// rtl/gelato_types_pkg.sv - shared warp/PC/split-table types and default sizes for the gelato front end
// Provides the default size macros used as parameter defaults (WARP_NUM, WARP_NUM_WIDTH,
// SPLIT_TABLE_NUM_WIDTH) when the build does not supply them, plus the common typedefs.
// Optional feature macro used by the scheduler: GELATO_FETCH_PERF_EN.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif
`ifndef WARP_NUM_WIDTH
`define WARP_NUM_WIDTH 2
`endif
`ifndef SPLIT_TABLE_NUM_WIDTH
`define SPLIT_TABLE_NUM_WIDTH 3
`endif

package gelato_types;

    localparam int GELATO_WARP_NUM        = `WARP_NUM;
    localparam int GELATO_WARP_NUM_WIDTH  = `WARP_NUM_WIDTH;
    localparam int GELATO_PC_WIDTH        = 32;
    localparam int GELATO_SPLIT_NUM_WIDTH = `SPLIT_TABLE_NUM_WIDTH;

    typedef logic [GELATO_WARP_NUM_WIDTH-1:0]  warp_num_t;
    typedef logic [GELATO_PC_WIDTH-1:0]        pc_t;
    typedef logic [GELATO_SPLIT_NUM_WIDTH-1:0] split_table_num_t;

    // WAIT means the warp has an instruction somewhere in the front end.
    typedef enum logic {
        READY = 1'b0,
        WAIT  = 1'b1
    } warp_state_e;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// rtl/gelato_rr_arbiter.sv - combinational round-robin arbiter over N requesters
// Ports:
//   req         in  N   request vector
//   ptr         in  W   index where the search begins (highest priority)
//   grant_valid out 1   at least one request is set
//   grant_idx   out W   first requester at or after ptr, wrapping modulo N
module gelato_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    int idx;

    // Wrap is an explicit subtract so non-power-of-two N works.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// rtl/gelato_fetch_scheduler.sv - round-robin warp fetch scheduler feeding the instruction cache
// Ports:
//   clk, rst_n (sync active-low), rdy (global enable; low freezes everything)
//   pct_valid/pct_pc/pct_split_num      per-warp PC table from the split table (flattened)
//   activate_valid/activate_warp_num    decode releases a warp back to READY
//   fetch_valid/fetch_ready/fetch_pc/fetch_warp_num/fetch_split_num  icache request
//   inflight                            per-warp WAIT status
//   perf_issue_cnt/perf_stall_cnt       only when GELATO_FETCH_PERF_EN is defined
module gelato_fetch_scheduler
    import gelato_types::*;
#(
    parameter int WARP_NUM        = `WARP_NUM,
    parameter int WARP_NUM_WIDTH  = `WARP_NUM_WIDTH,
    parameter int PC_WIDTH        = 32,
    parameter int SPLIT_NUM_WIDTH = `SPLIT_TABLE_NUM_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 rdy,
    input  logic [WARP_NUM-1:0]                  pct_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0]         pct_pc,
    input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0]  pct_split_num,
    input  logic                                 activate_valid,
    input  logic [WARP_NUM_WIDTH-1:0]            activate_warp_num,
    output logic                                 fetch_valid,
    input  logic                                 fetch_ready,
    output logic [PC_WIDTH-1:0]                  fetch_pc,
    output logic [WARP_NUM_WIDTH-1:0]            fetch_warp_num,
    output logic [SPLIT_NUM_WIDTH-1:0]           fetch_split_num,
    output logic [WARP_NUM-1:0]                  inflight
`ifdef GELATO_FETCH_PERF_EN
    ,
    output logic [31:0]                          perf_issue_cnt,
    output logic [31:0]                          perf_stall_cnt
`endif
);

    warp_state_e                  state_q [WARP_NUM];
    warp_state_e                  state_d [WARP_NUM];
    logic [WARP_NUM_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic                         fetch_valid_q, fetch_valid_d;
    logic [PC_WIDTH-1:0]          fetch_pc_q, fetch_pc_d;
    logic [WARP_NUM_WIDTH-1:0]    fetch_warp_q, fetch_warp_d;
    logic [SPLIT_NUM_WIDTH-1:0]   fetch_split_q, fetch_split_d;

    logic [WARP_NUM-1:0]          eligible;
    logic                         grant_valid;
    logic [WARP_NUM_WIDTH-1:0]    grant_idx;
    logic                         accept;
    logic                         load;

    assign accept = fetch_valid_q && fetch_ready;
    // The output register can take a new winner when empty or draining this cycle.
    assign load   = !fetch_valid_q || fetch_ready;

    // A warp sitting in the output register is still READY until accepted,
    // so it must be masked explicitly to avoid granting it twice.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            eligible[i] = pct_valid[i] && (state_q[i] == READY) &&
                          !(fetch_valid_q && (fetch_warp_q == WARP_NUM_WIDTH'(i)));
        end
    end

    gelato_rr_arbiter #(
        .N (WARP_NUM),
        .W (WARP_NUM_WIDTH)
    ) u_rr_arbiter (
        .req         (eligible),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_warp_d  = fetch_warp_q;
        fetch_split_d = fetch_split_q;
        if (rdy) begin
            for (int i = 0; i < WARP_NUM; i++) begin
                if (activate_valid && (activate_warp_num == WARP_NUM_WIDTH'(i)) &&
                    (state_q[i] == WAIT)) begin
                    state_d[i] = READY;
                end
                if (accept && (fetch_warp_q == WARP_NUM_WIDTH'(i))) begin
                    state_d[i] = WAIT;
                end
            end
            if (load) begin
                fetch_valid_d = grant_valid;
                if (grant_valid) begin
                    fetch_pc_d    = pct_pc[int'(grant_idx)*PC_WIDTH +: PC_WIDTH];
                    fetch_split_d = pct_split_num[int'(grant_idx)*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
                    fetch_warp_d  = grant_idx;
                    rr_ptr_d      = (grant_idx == WARP_NUM_WIDTH'(WARP_NUM-1)) ?
                                    '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WARP_NUM; i++) begin
                state_q[i] <= READY;
            end
            rr_ptr_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_warp_q  <= '0;
            fetch_split_q <= '0;
        end else begin
            for (int i = 0; i < WARP_NUM; i++) begin
                state_q[i] <= state_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_warp_q  <= fetch_warp_d;
            fetch_split_q <= fetch_split_d;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            inflight[i] = (state_q[i] == WAIT);
        end
    end

    assign fetch_valid     = fetch_valid_q;
    assign fetch_pc        = fetch_pc_q;
    assign fetch_warp_num  = fetch_warp_q;
    assign fetch_split_num = fetch_split_q;

`ifdef GELATO_FETCH_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        if (rdy) begin
            if (accept && (perf_issue_q != '1)) begin
                perf_issue_d = perf_issue_q + 32'd1;
            end
            if (fetch_valid_q && !fetch_ready && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

`ifndef SYNTHESIS
    // Decode may only release a warp that is actually in flight, and never
    // the one being accepted in the same cycle.
    always @(posedge clk) begin
        if (rst_n && rdy && activate_valid) begin
            assert (inflight[activate_warp_num])
                else $error("activate for warp %0d that is not in WAIT", activate_warp_num);
            assert (!(accept && (fetch_warp_q == activate_warp_num)))
                else $error("activate and accept for warp %0d in the same cycle", activate_warp_num);
        end
    end
`endif

endmodule
